// File: rtl/ff_ctrl_pkg.sv
// Shared encodings for the flip-flop mode sequencer: command modes and
// controller FSM states.
package ff_ctrl_pkg;

  typedef enum logic [1:0] {
    MODE_SR = 2'b00,
    MODE_JK = 2'b01,
    MODE_D  = 2'b10,
    MODE_T  = 2'b11
  } mode_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_APPLY = 2'b01,
    ST_DONE  = 2'b10
  } state_t;

endpackage

// File: rtl/sr_ff.sv
// Single SR storage element shared by every flip-flop personality.
module sr_ff (
  input  logic clk,
  input  logic rst,
  input  logic s,
  input  logic r,
  output logic q
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) q <= 1'b0;
    else     q <= s | (~r & q);
  end

endmodule

// File: rtl/ff_mode_sequencer.sv
// Command-driven controller that drives one SR core as an SR, JK, D or T
// flip-flop for a programmed number of clock edges.
module ff_mode_sequencer
  import ff_ctrl_pkg::*;
#(
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [1:0]       cmd_mode,
  input  logic             cmd_a,
  input  logic             cmd_b,
  input  logic [CNT_W-1:0] cmd_count,
  output logic             s,
  output logic             r,
  output logic             q,
  output logic             busy,
  output logic             done,
  output logic             err
);

  state_t           state, state_nx;
  mode_t            mode_q;
  logic             a_q, b_q;
  logic [CNT_W-1:0] remaining;
  logic             hs, illegal;

  assign cmd_ready = (state == ST_IDLE);
  assign busy      = (state != ST_IDLE);
  assign hs        = cmd_valid & cmd_ready;
  assign illegal   = (mode_t'(cmd_mode) == MODE_SR) & cmd_a & cmd_b;

  always_comb begin
    state_nx = state;
    case (state)
      ST_IDLE: begin
        if (hs && !illegal)
          state_nx = (cmd_count == '0) ? ST_DONE : ST_APPLY;
      end
      ST_APPLY: begin
        // Exit on the last edge so remaining never has to wrap through zero.
        if (remaining == CNT_W'(1)) state_nx = ST_DONE;
      end
      ST_DONE:  state_nx = ST_IDLE;
      default:  state_nx = ST_IDLE;
    endcase
  end

  // Excitation: translate the latched personality into S/R drive so S=R=1
  // can never reach the core.
  always_comb begin
    s = 1'b0;
    r = 1'b0;
    if (state == ST_APPLY) begin
      case (mode_q)
        MODE_SR: begin s = a_q;       r = b_q;       end
        MODE_JK: begin s = a_q & ~q;  r = b_q & q;   end
        MODE_D:  begin s = a_q;       r = ~a_q;      end
        MODE_T:  begin s = a_q & ~q;  r = a_q & q;   end
        default: begin s = 1'b0;      r = 1'b0;      end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ST_IDLE;
      mode_q    <= MODE_SR;
      a_q       <= 1'b0;
      b_q       <= 1'b0;
      remaining <= '0;
      done      <= 1'b0;
      err       <= 1'b0;
    end else begin
      state <= state_nx;
      done  <= (state_nx == ST_DONE);
      err   <= hs & illegal;
      if (hs && !illegal) begin
        mode_q    <= mode_t'(cmd_mode);
        a_q       <= cmd_a;
        b_q       <= cmd_b;
        remaining <= cmd_count;
      end else if (state == ST_APPLY) begin
        remaining <= remaining - CNT_W'(1);
      end
    end
  end

  sr_ff u_core (
    .clk (clk),
    .rst (rst),
    .s   (s),
    .r   (r),
    .q   (q)
  );

endmodule
